// File: rtl/multiplier_pkg.sv
// Shared constants and types for the modular multiplier / reduction datapath.
package multiplier_pkg;

    localparam int unsigned DATA_LENGTH      = 16;
    localparam int unsigned KYBER_Q          = 3329;
    localparam int unsigned RED_PIPE_LATENCY = 4;

    typedef enum logic [1:0] {
        DRV_IDLE,
        DRV_RUN,
        DRV_DRAIN
    } drv_state_t;

endpackage

// File: rtl/red_result_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push and pop may coincide even when full.
module red_result_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reduction_driver.sv
// Initiator for the no-backpressure reduction pipeline: credit-limited issue, in-order result
// collection and a valid/ready result stream.
module reduction_driver #(
    parameter int unsigned DATA_LENGTH      = multiplier_pkg::DATA_LENGTH,
    parameter int unsigned RES_DEPTH        = 8,
    parameter int unsigned RED_PIPE_LATENCY = multiplier_pkg::RED_PIPE_LATENCY
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [DATA_LENGTH-1:0] cfg_m_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_data_i,
    input  logic                   in_last_i,
    output logic                   red_start_o,
    output logic [DATA_LENGTH-1:0] red_x_o,
    output logic [DATA_LENGTH-1:0] red_m_o,
    input  logic                   red_valid_i,
    input  logic [DATA_LENGTH-1:0] red_result_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_data_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   err_o
);

    import multiplier_pkg::*;

    localparam int unsigned CW = $clog2(RES_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(RES_DEPTH);
    localparam logic [DATA_LENGTH-1:0] M_RESET = DATA_LENGTH'(KYBER_Q);

    if (((RES_DEPTH & (RES_DEPTH - 1)) != 0) || (RES_DEPTH < RED_PIPE_LATENCY)) begin : g_bad_depth
        $error("RES_DEPTH must be a power of 2 and at least RED_PIPE_LATENCY");
    end

    drv_state_t             state_q;
    logic [DATA_LENGTH-1:0] m_q;
    logic [DATA_LENGTH-1:0] x_q;
    logic                   start_q;
    logic                   err_q;
    logic [CW-1:0]          outstanding_q;

    logic                   accept;
    logic                   ret;
    logic                   stray;
    logic                   overflow;
    logic [CW:0]            credit_used;

    logic                   tag_head;
    logic                   tag_empty;
    logic                   tag_full;
    logic [CW-1:0]          tag_count;

    logic [DATA_LENGTH:0]   res_head;
    logic                   res_empty;
    logic                   res_full;
    logic                   res_pop;
    logic [CW-1:0]          res_count;

    // Every issued coefficient owns a result slot until it is popped downstream.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, res_count};
    assign in_ready_o  = (state_q != DRV_DRAIN) && (credit_used < CREDIT_LIMIT);
    assign accept      = in_valid_i && in_ready_o;

    assign ret         = red_valid_i && (outstanding_q != '0);
    assign stray       = red_valid_i && (outstanding_q == '0);
    assign res_pop     = !res_empty && out_ready_i;
    assign overflow    = ret && res_full && !res_pop;

    red_result_fifo #(
        .WIDTH (1),
        .DEPTH (RES_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (in_last_i),
        .pop_i   (ret),
        .data_o  (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full),
        .count_o (tag_count)
    );

    red_result_fifo #(
        .WIDTH (DATA_LENGTH + 1),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ret),
        .data_i  ({red_result_i, tag_head}),
        .pop_i   (res_pop),
        .data_o  (res_head),
        .empty_o (res_empty),
        .full_o  (res_full),
        .count_o (res_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= DRV_IDLE;
            m_q           <= M_RESET;
            x_q           <= '0;
            start_q       <= 1'b0;
            err_q         <= 1'b0;
            outstanding_q <= '0;
        end else begin
            start_q <= accept;
            if (accept) begin
                x_q <= in_data_i;
            end
            if (accept && !ret) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (!accept && ret) begin
                outstanding_q <= outstanding_q - 1'b1;
            end
            if (stray || overflow) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                DRV_IDLE: begin
                    if (cfg_we_i) begin
                        m_q <= cfg_m_i;
                    end
                    // A single-beat batch goes straight to draining.
                    if (accept && in_last_i) begin
                        state_q <= DRV_DRAIN;
                    end else if (in_valid_i) begin
                        state_q <= DRV_RUN;
                    end
                end
                DRV_RUN: begin
                    if (accept && in_last_i) begin
                        state_q <= DRV_DRAIN;
                    end
                end
                DRV_DRAIN: begin
                    if ((outstanding_q == '0) && res_empty) begin
                        state_q <= DRV_IDLE;
                    end
                end
                default: state_q <= DRV_IDLE;
            endcase
        end
    end

    assign red_start_o = start_q;
    assign red_x_o     = x_q;
    assign red_m_o     = m_q;
    assign out_valid_o = !res_empty;
    assign out_data_o  = res_head[DATA_LENGTH:1];
    assign out_last_o  = res_head[0];
    assign busy_o      = (state_q != DRV_IDLE);
    assign err_o       = err_q;

    // The tag FIFO mirrors the outstanding counter one-for-one.
    a_tag_tracks_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        tag_count == outstanding_q);
    a_no_tag_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        accept |-> !tag_full);
    a_tag_on_return: assert property (@(posedge clk_i) disable iff (rst_i)
        ret |-> !tag_empty);

endmodule

// File: tb/tb_reduction_driver.sv
// Bench for reduction_driver: a latency-accurate pipeline stand-in plus a queue-based result model.
module tb_reduction_driver;

    import multiplier_pkg::*;

    localparam int unsigned DL    = multiplier_pkg::DATA_LENGTH;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LAT   = multiplier_pkg::RED_PIPE_LATENCY;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_we_i;
    logic [DL-1:0] cfg_m_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DL-1:0] in_data_i;
    logic          in_last_i;
    logic          red_start_o;
    logic [DL-1:0] red_x_o;
    logic [DL-1:0] red_m_o;
    logic          red_valid_i;
    logic [DL-1:0] red_result_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DL-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          err_o;

    typedef struct {
        logic [DL-1:0] data;
        logic          last;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned model_m;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        force_valid = 1'b0;

    always #5 clk_i = ~clk_i;

    reduction_driver #(
        .DATA_LENGTH      (DL),
        .RES_DEPTH        (DEPTH),
        .RED_PIPE_LATENCY (LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_m_i      (cfg_m_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_last_i    (in_last_i),
        .red_start_o  (red_start_o),
        .red_x_o      (red_x_o),
        .red_m_o      (red_m_o),
        .red_valid_i  (red_valid_i),
        .red_result_i (red_result_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // Pipeline stand-in: not reset, so a reset mid-batch leaves stray results in flight.
    logic [LAT-1:0] pv = '0;
    logic [DL-1:0]  pr [LAT];
    always @(posedge clk_i) begin
        pv    <= {pv[LAT-2:0], red_start_o};
        pr[0] <= red_x_o % red_m_o;
        for (int i = 1; i < LAT; i++) begin
            pr[i] <= pr[i-1];
        end
    end
    assign red_valid_i  = pv[LAT-1] | force_valid;
    assign red_result_i = pr[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes at the negedge, return 1 ns after the next posedge.
    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk_i);
        acc = 1'b0;
        if (!rst_i) begin
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_data_o), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data_o), 32'(e.data));
                    check("out_last", 32'(out_last_o), 32'(e.last));
                end
            end
            if (in_valid_i && in_ready_o) begin
                acc    = 1'b1;
                e.data = DL'(32'(in_data_i) % model_m);
                e.last = in_last_i;
                exp_q.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int cap);
        bit a;
        int n = 0;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        while ((exp_q.size() != 0 || busy_o) && n < cap) begin
            tick(a);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", 32'(busy_o), 0);
    endtask

    task automatic send_batch(input int n, input bit rnd);
        bit a;
        int sent  = 0;
        int guard = 0;
        in_data_i = DL'($urandom);
        in_last_i = (n == 1);
        while (sent < n && guard < 2000) begin
            in_valid_i  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick(a);
            guard++;
            if (a) begin
                sent++;
                in_data_i = DL'($urandom);
                in_last_i = (sent == n - 1);
            end
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        check("batch_sent", sent, n);
        drain(500);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit      a;
        int      acc_cnt;
        int      cyc;
        logic [DL-1:0] burst [16];

        rst_i       = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_m_i     = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        model_m     = KYBER_Q;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset state
        check("rst_m", 32'(red_m_o), 3329);
        check("rst_start", 32'(red_start_o), 0);
        check("rst_x", 32'(red_x_o), 0);
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_err", 32'(err_o), 0);
        rst_i = 1'b0;

        cfg_we_i = 1'b1;
        cfg_m_i  = 16'd3329;
        tick(a);
        cfg_we_i = 1'b0;
        check("cfg_m", 32'(red_m_o), 3329);
        check("cfg_busy", 32'(busy_o), 0);

        // Single beat: 10000 mod 3329 = 13
        in_valid_i = 1'b1;
        in_data_i  = 16'd10000;
        in_last_i  = 1'b1;
        tick(a);
        check("single_accept", 32'(a), 1);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        check("single_start", 32'(red_start_o), 1);
        check("single_x", 32'(red_x_o), 10000);
        tick(a);
        check("single_start_pulse", 32'(red_start_o), 0);
        cyc = 1;
        while (!out_valid_o && cyc < 20) begin
            tick(a);
            cyc++;
        end
        // Output valid in the 6th cycle after the accept cycle, i.e. 5 edges after accept.
        check("single_latency", cyc, 5);
        check("single_data", 32'(out_data_o), 13);
        check("single_last", 32'(out_last_o), 1);
        out_ready_i = 1'b1;
        tick(a);
        check("single_busy_after_pop", 32'(busy_o), 1);
        tick(a);
        check("single_busy_fall", 32'(busy_o), 0);
        check("single_model_empty", exp_q.size(), 0);

        // Burst of 16 at full rate
        burst[0] = 16'd6663;
        burst[1] = 16'd3330;
        burst[2] = 16'd12;
        for (int i = 3; i < 16; i++) begin
            burst[i] = DL'($urandom);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = burst[i];
            in_last_i  = (i == 15);
            tick(a);
            check("burst_ready", 32'(a), 1);
        end
        drain(100);

        // Backpressure: credits run out after DEPTH accepts
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_last_i   = 1'b0;
        in_data_i   = DL'($urandom);
        acc_cnt     = 0;
        repeat (20) begin
            tick(a);
            if (a) begin
                acc_cnt++;
                in_data_i = DL'($urandom);
            end
        end
        check("bp_accepts", acc_cnt, DEPTH);
        check("bp_ready_low", 32'(in_ready_o), 0);
        check("bp_out_valid", 32'(out_valid_o), 1);
        check("bp_err", 32'(err_o), 0);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (DEPTH) tick(a);
        check("bp_drained", exp_q.size(), 0);
        check("bp_ready_back", 32'(in_ready_o), 1);
        send_batch(5, 1'b0);

        // Stray result while idle
        force_valid = 1'b1;
        tick(a);
        force_valid = 1'b0;
        check("stray_err", 32'(err_o), 1);
        check("stray_fifo", 32'(out_valid_o), 0);

        // Config write during RUN is ignored
        in_valid_i = 1'b1;
        in_data_i  = DL'($urandom);
        in_last_i  = 1'b0;
        tick(a);
        in_valid_i = 1'b0;
        cfg_we_i   = 1'b1;
        cfg_m_i    = 16'd77;
        tick(a);
        cfg_we_i   = 1'b0;
        check("cfg_in_run", 32'(red_m_o), 3329);
        in_valid_i = 1'b1;
        in_last_i  = 1'b1;
        in_data_i  = DL'($urandom);
        tick(a);
        drain(100);

        // Reset with three results outstanding
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = DL'($urandom);
            tick(a);
        end
        in_valid_i = 1'b0;
        tick(a);
        rst_i = 1'b1;
        #1;
        check("mid_rst_start", 32'(red_start_o), 0);
        check("mid_rst_x", 32'(red_x_o), 0);
        check("mid_rst_out_valid", 32'(out_valid_o), 0);
        check("mid_rst_out_data", 32'(out_data_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_err", 32'(err_o), 0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (LAT + 2) tick(a);
        check("late_err", 32'(err_o), 1);
        check("late_out_valid", 32'(out_valid_o), 0);
        check("late_busy", 32'(busy_o), 0);

        // Fresh randomized batches under different moduli
        cfg_we_i = 1'b1;
        cfg_m_i  = 16'd7681;
        tick(a);
        cfg_we_i = 1'b0;
        model_m  = 7681;
        check("cfg_7681", 32'(red_m_o), 7681);
        send_batch(12, 1'b1);

        cfg_we_i = 1'b1;
        cfg_m_i  = 16'd17;
        tick(a);
        cfg_we_i = 1'b0;
        model_m  = 17;
        check("cfg_17", 32'(red_m_o), 17);
        send_batch(24, 1'b1);

        cfg_we_i = 1'b1;
        cfg_m_i  = 16'd3329;
        tick(a);
        cfg_we_i = 1'b0;
        model_m  = 3329;
        send_batch(1, 1'b0);
        check("final_err_sticky", 32'(err_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
